// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 8-bit slice, one byte per clock, LSB first.
// Optional macro ADDSUB_SEQ_SATURATE_EN clamps overflowed results to the signed extreme.
module addsub_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  busy
);

  localparam int W = 8 * NBYTES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         op_q;
  logic         cin_q;
  logic [3:0]   idx;
  logic [W-1:0] result_q;
  logic         carry_q;
  logic         ovf_q;
  logic         zero_q;

  logic [7:0]   a_byte;
  logic [7:0]   b_byte;
  logic [7:0]   lo_sum;
  logic [1:0]   hi_sum;
  logic [7:0]   sum_byte;
  logic         c_out;
  logic         slice_ovf;
  logic         last;
  logic [W-1:0] full_res;
  logic [W-1:0] final_res;

  // The slice is split at bit 7 so the carry into the MSB is available for the overflow flag.
  always_comb begin
    a_byte    = a_q[7:0];
    b_byte    = b_q[7:0] ^ {8{op_q}};
    lo_sum    = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'b0, cin_q};
    hi_sum    = {1'b0, a_byte[7]} + {1'b0, b_byte[7]} + {1'b0, lo_sum[7]};
    sum_byte  = {hi_sum[0], lo_sum[6:0]};
    c_out     = hi_sum[1];
    slice_ovf = lo_sum[7] ^ hi_sum[1];
    last      = (idx == 4'(NBYTES - 1));
    full_res  = {sum_byte, result_q[W-1:8]};
`ifdef ADDSUB_SEQ_SATURATE_EN
    // On the last byte a_byte holds A's top byte, so its MSB gives the overflow direction.
    if (slice_ovf)
      final_res = a_byte[7] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      final_res = full_res;
`else
    final_res = full_res;
`endif
  end

  // Operands shift down a byte per RUN cycle; result bytes enter from the top so the
  // final byte completes the word in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      cin_q    <= 1'b0;
      idx      <= 4'd0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_sub;
            cin_q <= op_sub;
            idx   <= 4'd0;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= {8'h00, a_q[W-1:8]};
          b_q   <= {8'h00, b_q[W-1:8]};
          cin_q <= c_out;
          idx   <= idx + 4'd1;
          if (last) begin
            result_q <= final_res;
            carry_q  <= c_out ^ op_q;
            ovf_q    <= slice_ovf;
            zero_q   <= (final_res == '0);
            state    <= DONE;
          end else begin
            result_q <= full_res;
          end
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign result      = result_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed self-checking bench for addsub_seq_ctrl at NBYTES=4.
// Expected results follow ADDSUB_SEQ_SATURATE_EN when it is defined.
module tb_addsub_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;

  int total = 0;
  int bad   = 0;

  addsub_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_sub(op_sub), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Launches one operation and scrambles the inputs right after accept; returns the
  // number of cycles until res_valid (capped at 20).
  task automatic run_op(input logic sub, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int lat);
    @(negedge clk);
    start_valid = 1'b1; op_sub = sub; a = ia; b = ib;
    @(negedge clk);
    start_valid = 1'b0; op_sub = ~sub; a = ~ia; b = ~ib ^ 32'h5A5A_5A5A;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic sub, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [W-1:0] er, input logic ec,
                          input logic eo, input logic ez);
    int lat;
    run_op(sub, ia, ib, lat);
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL %s latency: got %0d want 4", name, lat); end
    total++;
    if (result !== er) begin bad++; $display("[TB] FAIL %s result: got %h want %h", name, result, er); end
    total++;
    if (carry !== ec) begin bad++; $display("[TB] FAIL %s carry: got %b want %b", name, carry, ec); end
    total++;
    if (overflow !== eo) begin bad++; $display("[TB] FAIL %s overflow: got %b want %b", name, overflow, eo); end
    total++;
    if (zero !== ez) begin bad++; $display("[TB] FAIL %s zero: got %b want %b", name, zero, ez); end
    release_result();
    total++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s release: got valid=%b ready=%b busy=%b want 0 1 0",
               name, res_valid, start_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset handshake: got ready=%b valid=%b busy=%b want 1 0 0",
               start_ready, res_valid, busy);
    end
    total++;
    if (result !== 32'h0 || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset outputs: got res=%h c=%b o=%b z=%b want 0 0 0 0",
               result, carry, overflow, zero);
    end
  endtask

  task automatic test_add();
    check_op("add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    check_op("add_wrap", 1'b0, 32'h89AB_CDEF, 32'h7654_3211, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    check_op("sub_0_1", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check_op("sub_eq", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
`ifdef ADDSUB_SEQ_SATURATE_EN
    check_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    check_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`else
    check_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    check_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int stable_bad;
    run_op(1'b0, 32'h1111_1111, 32'h2222_2222, lat);
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL hold latency: got %0d want 4", lat); end
    // A new request waits at the input while the consumer stalls.
    start_valid = 1'b1; op_sub = 1'b0; a = 32'h0000_0001; b = 32'h0000_0001;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 32'h3333_3333 || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0 ||
          res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1)
        stable_bad++;
    end
    total++;
    if (stable_bad !== 0) begin
      bad++;
      $display("[TB] FAIL hold stable: got %0d bad cycles, last res=%h valid=%b ready=%b want 0",
               stable_bad, result, res_valid, start_ready);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold to idle: got ready=%b valid=%b want 1 0", start_ready, res_valid);
    end
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4 || result !== 32'h0000_0002) begin
      bad++;
      $display("[TB] FAIL queued op: got lat=%0d res=%h want 4 00000002", lat, result);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start_valid = 1'b1; op_sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 ||
        carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid reset: got ready=%b valid=%b busy=%b res=%h c=%b o=%b z=%b want 1 0 0 0 0 0 0",
               start_ready, res_valid, busy, result, carry, overflow, zero);
    end
    repeat (4) @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid reset idle: got valid=%b busy=%b want 0 0", res_valid, busy);
    end
    check_op("post_reset", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
